// File: rtl/tjk_mod_counter.sv
// tjk_mod_counter: modulo-MOD up/down/load counter built from JK cells.
// Each state bit is a JK flip-flop with J=K=t_out[i]. The combinational
// block works out which bits must toggle to reach the next count. The
// registered wrap and err outputs flag modulus roll-over and clamped loads.
module tjk_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] t_out,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Largest legal count, and the modulus widened by one bit so that a
    // full-range modulus stays representable in comparisons.
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);

    mode_e            op;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH:0]   q_inc;
    logic             up_wraps;
    logic             at_top;
    logic             at_zero;
    logic             load_ok;
    logic             wrap_nxt;
    logic             err_nxt;

    assign op = mode_e'(mode);

    // qb is derived from q, never stored separately, so it tracks q through reset.
    assign qb = ~q;

    // Up steps that start at TOP, or at any stray value above it, clear to 0.
    assign q_inc    = {1'b0, q} + ONE_EXT;
    assign up_wraps = (q_inc >= MOD_EXT);
    assign at_top   = (q == TOP);
    assign at_zero  = (q == '0);
    assign load_ok  = ({1'b0, d} < MOD_EXT);

    // Ripple toggle chains: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry_up;
        logic carry_dn;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        up_t     = '0;
        dn_t     = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i]  = carry_up;
            dn_t[i]  = carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & qb[i];
        end
    end

    // Toggle selection, terminal count and next-cycle pulse requests.
    always_comb begin
        t_out    = '0;
        tc       = 1'b0;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (en) begin
            case (op)
                MODE_UP: begin
                    tc = at_top;
                    if (up_wraps) begin
                        t_out    = q;
                        wrap_nxt = 1'b1;
                    end else begin
                        t_out = up_t;
                    end
                end
                MODE_DOWN: begin
                    tc = at_zero;
                    if (at_zero) begin
                        t_out    = TOP;
                        wrap_nxt = 1'b1;
                    end else begin
                        t_out = dn_t;
                    end
                end
                MODE_LOAD: begin
                    if (load_ok) begin
                        t_out = q ^ d;
                    end else begin
                        t_out   = q ^ TOP;
                        err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // JK characteristic equation: Q+ = J & ~Q | ~K & Q.
    function automatic logic jk_next(input logic qc, input logic j, input logic k);
        return (j & ~qc) | (~k & qc);
    endfunction

    // State bits and pulse flags; synchronous reset takes priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q[i] <= jk_next(q[i], t_out[i], t_out[i]);
            end
            wrap <= wrap_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tjk_mod_counter.sv
// Bench for tjk_mod_counter: a MOD=10 and a MOD=16 instance share one
// stimulus stream. An arithmetic reference model is compared every cycle,
// and directed literal checks pin both the model and the DUT.
module tb_tjk_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] d = 4'd0;

    logic [3:0] q10, qb10, t10;
    logic       tc10, wrap10, err10;
    logic [3:0] q16, qb16, t16;
    logic       tc16, wrap16, err16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tjk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .q(q10), .qb(qb10), .t_out(t10), .tc(tc10), .wrap(wrap10), .err(err10)
    );

    tjk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .q(q16), .qb(qb16), .t_out(t16), .tc(tc16), .wrap(wrap16), .err(err16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    typedef struct packed {
        int q;
        bit w;
        bit e;
    } mstate_t;

    function automatic mstate_t model_step(input int qv, input int modv, input bit e_in,
                                           input bit [1:0] m, input int dv);
        mstate_t r;
        r.q = qv;
        r.w = 1'b0;
        r.e = 1'b0;
        if (e_in) begin
            case (m)
                2'd1: begin
                    if (qv >= modv - 1) begin r.q = 0; r.w = 1'b1; end
                    else r.q = qv + 1;
                end
                2'd2: begin
                    if (qv == 0) begin r.q = modv - 1; r.w = 1'b1; end
                    else r.q = qv - 1;
                end
                2'd3: begin
                    if (dv < modv) r.q = dv;
                    else begin r.q = modv - 1; r.e = 1'b1; end
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic bit model_tc(input int qv, input int modv, input bit e_in, input bit [1:0] m);
        return e_in && ((m == 2'd1 && qv == modv - 1) || (m == 2'd2 && qv == 0));
    endfunction

    mstate_t m10, m16;
    bit      valid = 1'b0;

    // Model state advances on each rising edge; meaningful only after the first reset.
    always @(posedge clk) begin
        if (rst) begin
            m10   <= '0;
            m16   <= '0;
            valid <= 1'b1;
        end else if (valid) begin
            m10 <= model_step(m10.q, 10, en, mode, int'(d));
            m16 <= model_step(m16.q, 16, en, mode, int'(d));
        end
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mstate_t n10, n16;
        if (valid) begin
            n10 = model_step(m10.q, 10, en, mode, int'(d));
            n16 = model_step(m16.q, 16, en, mode, int'(d));
            check("m10.q",    32'(q10),    32'(m10.q));
            check("m10.qb",   32'(qb10),   32'((~m10.q) & 15));
            check("m10.wrap", 32'(wrap10), 32'(m10.w));
            check("m10.err",  32'(err10),  32'(m10.e));
            check("m10.tout", 32'(t10),    32'((m10.q ^ n10.q) & 15));
            check("m10.tc",   32'(tc10),   32'(model_tc(m10.q, 10, en, mode)));
            check("m16.q",    32'(q16),    32'(m16.q));
            check("m16.qb",   32'(qb16),   32'((~m16.q) & 15));
            check("m16.wrap", 32'(wrap16), 32'(m16.w));
            check("m16.err",  32'(err16),  32'(m16.e));
            check("m16.tout", 32'(t16),    32'((m16.q ^ n16.q) & 15));
            check("m16.tc",   32'(tc16),   32'(model_tc(m16.q, 16, en, mode)));
        end
    end

    // Drive one cycle of inputs just after a rising edge, then wait for the
    // falling edge, where combinational outputs reflect these inputs and the
    // registered outputs reflect the previous cycle.
    task automatic apply(input logic r, input logic e, input logic [1:0] m, input logic [3:0] dv);
        @(posedge clk);
        #1;
        rst  = r;
        en   = e;
        mode = m;
        d    = dv;
        @(negedge clk);
    endtask

    initial begin
        // Reset, then load 7, then reset while counting up.
        apply(1'b1, 1'b0, 2'd0, 4'd0);
        check("rst.q", 32'(q10), 32'h0);
        check("rst.qb", 32'(qb10), 32'hF);
        apply(1'b0, 1'b1, 2'd3, 4'd7);
        check("load7.tout", 32'(t10), 32'h7);
        apply(1'b1, 1'b1, 2'd1, 4'd0);
        check("q7", 32'(q10), 32'h7);
        check("up7.tout", 32'(t10), 32'hF);
        apply(1'b0, 1'b1, 2'd1, 4'd0);
        check("rst7.q", 32'(q10), 32'h0);
        check("rst7.qb", 32'(qb10), 32'hF);
        check("rst7.wrap", 32'(wrap10), 32'h0);

        // Up through the MOD=10 boundary, switching to down on the final cycle.
        for (int k = 1; k <= 10; k++) begin
            apply(1'b0, 1'b1, (k < 10) ? 2'd1 : 2'd2, 4'd0);
            check("up.q", 32'(q10), 32'(k % 10));
            check("up.wrap", 32'(wrap10), (k == 10) ? 32'h1 : 32'h0);
            if (k == 9) begin
                check("up9.tc", 32'(tc10), 32'h1);
                check("up9.tout", 32'(t10), 32'h9);
            end
        end
        check("dn0.tout", 32'(t10), 32'h9);
        check("dn0.tc", 32'(tc10), 32'h1);
        apply(1'b0, 1'b1, 2'd2, 4'd0);
        check("dn.q9", 32'(q10), 32'h9);
        check("dn.wrap", 32'(wrap10), 32'h1);
        check("dn9.tout", 32'(t10), 32'h1);
        apply(1'b0, 1'b1, 2'd3, 4'd5);
        check("dn.q8", 32'(q10), 32'h8);
        check("dn8.wrap", 32'(wrap10), 32'h0);

        // Hold with en=0 while mode requests up.
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 2'd1, 4'd0);
            check("hold.q", 32'(q10), 32'h5);
            check("hold.qb", 32'(qb10), 32'hA);
            check("hold.tout", 32'(t10), 32'h0);
            check("hold.tc", 32'(tc10), 32'h0);
        end

        // Out-of-range load clamps to 9 with err; in-range loads do not wrap.
        apply(1'b0, 1'b1, 2'd3, 4'd12);
        check("ld12.tout", 32'(t10), 32'hC);
        apply(1'b0, 1'b1, 2'd3, 4'd3);
        check("ld12.q", 32'(q10), 32'h9);
        check("ld12.err", 32'(err10), 32'h1);
        check("ld12.wrap", 32'(wrap10), 32'h0);
        check("ld3.tout", 32'(t10), 32'hA);
        apply(1'b0, 1'b1, 2'd3, 4'd9);
        check("ld3.q", 32'(q10), 32'h3);
        check("ld3.err", 32'(err10), 32'h0);
        apply(1'b0, 1'b1, 2'd3, 4'd0);
        check("ld9.wrap", 32'(wrap10), 32'h0);
        apply(1'b0, 1'b0, 2'd0, 4'd0);
        check("ld0.q", 32'(q10), 32'h0);
        check("ld0.wrap", 32'(wrap10), 32'h0);

        // Full modulus instance: up from 15 overflows naturally.
        apply(1'b0, 1'b1, 2'd3, 4'd15);
        apply(1'b0, 1'b1, 2'd1, 4'd0);
        check("m16.q15", 32'(q16), 32'hF);
        check("m16.tout15", 32'(t16), 32'hF);
        check("m16.tc15", 32'(tc16), 32'h1);
        check("m16.err15", 32'(err16), 32'h0);
        apply(1'b0, 1'b0, 2'd0, 4'd0);
        check("m16.q0", 32'(q16), 32'h0);
        check("m16.wrap0", 32'(wrap16), 32'h1);

        // Reset on the same edge as an out-of-range load or a down-wrap: no pulses.
        apply(1'b1, 1'b1, 2'd3, 4'd14);
        apply(1'b1, 1'b1, 2'd2, 4'd0);
        check("rstld.err", 32'(err10), 32'h0);
        check("rstld.q", 32'(q10), 32'h0);
        apply(1'b0, 1'b1, 2'd1, 4'd0);
        check("rstdn.wrap", 32'(wrap10), 32'h0);
        apply(1'b0, 1'b0, 2'd0, 4'd0);
        check("resume.q", 32'(q10), 32'h1);

        // Random traffic checked by the model every cycle.
        for (int k = 0; k < 10000; k++) begin
            apply(($urandom % 64) == 0, ($urandom % 4) != 0,
                  2'($urandom % 4), 4'($urandom % 16));
        end
        apply(1'b0, 1'b0, 2'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tjk_mod_counter.md
TJK_MOD_COUNTER -- requirements
Module: tjk_mod_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 The block SHALL take parameter MOD, default 16: count modulus, legal range 2..2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count/load enable; 0 forces hold.
REQ-006 The block SHALL have port mode, input, 2 bits: operation select; 00 hold, 01 up, 10 down, 11 load.
REQ-007 The block SHALL have port d, input, WIDTH bits: parallel load value.
REQ-008 The block SHALL have port q, output, WIDTH bits: registered count.
REQ-009 The block SHALL have port qb, output, WIDTH bits: bitwise complement of q.
REQ-010 The block SHALL have port t_out, output, WIDTH bits: per-bit toggle enables for the next edge (combinational).
REQ-011 The block SHALL have port tc, output, 1 bit: terminal count (combinational).
REQ-012 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on modulus wrap.
REQ-013 The block SHALL have port err, output, 1 bit: registered one-cycle pulse on an out-of-range load.

Function
REQ-014 Each state bit SHALL be a JK cell with J=K=t_out[i]: the bit toggles when t_out[i]=1 and holds otherwise.
REQ-015 qb SHALL equal ~q in every cycle, including during and after reset; the two SHALL never be independently stored.
REQ-016 Hold (en=0 or mode=00) SHALL drive t_out=0; q unchanged; wrap=0 and err=0 on the next edge.
REQ-017 Up, normal step: when q<MOD-1, t_out[i] SHALL be the AND of q[i-1:0] (t_out[0]=1), so q becomes q+1.
REQ-018 Up at boundary: when q==MOD-1, t_out SHALL equal q, so q becomes 0 and wrap pulses next cycle.
REQ-019 Down, normal step: when q>0, t_out[i] SHALL be the AND of qb[i-1:0] (t_out[0]=1), so q becomes q-1.
REQ-020 Down at boundary: when q==0, t_out SHALL equal MOD-1, so q becomes MOD-1 and wrap pulses next cycle.
REQ-021 Load, in range: when d<MOD, t_out SHALL equal q XOR d and q becomes d; err=0.
REQ-022 Load, out of range: when d>=MOD, q SHALL become MOD-1 (t_out = q XOR (MOD-1)) and err pulses next cycle.
REQ-023 wrap SHALL never assert on a load, even when the loaded value is 0 or MOD-1.
REQ-024 tc SHALL be 1 when en=1 and either (mode=01 and q==MOD-1) or (mode=10 and q==0); otherwise 0.
REQ-025 Latency: q, wrap and err SHALL reflect the cycle-N inputs after edge N; tc and t_out SHALL be same-cycle combinational.
REQ-026 When MOD=2^WIDTH, wrap behaviour SHALL equal natural binary overflow and the err path SHALL be unreachable.
REQ-027 If q ever holds a value >=MOD, an up step SHALL go to 0 with wrap, and a down step SHALL behave per REQ-019.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL set q=0, qb=all ones, wrap=0 and err=0, regardless of en, mode or d.
REQ-029 While rst=1, rst SHALL take priority over an in-progress count or load; no wrap or err pulse SHALL follow a reset edge.
REQ-030 After rst deasserts, counting SHALL resume from 0 on the first enabled edge.
REQ-031 The block SHALL contain no initial-block or power-up assumptions; q is undefined until the first reset edge.

Verification
REQ-032 Reset: WIDTH=4, MOD=10, q=7, assert rst with mode=01 and en=1 -> next edge q=0, qb=4'hF, wrap=0.
REQ-033 Up wrap: MOD=10, count up from 0 for 10 edges -> q sequence 1..9 then 0; tc=1 while q=9; wrap=1 for exactly the cycle after q returns to 0.
REQ-034 Down wrap: MOD=10, q=0, mode=10 -> t_out=4'b1001, next q=9, wrap pulse; then q=8 with t_out=4'b0001.
REQ-035 Out-of-range load: MOD=10, mode=11, d=12 -> q=9, err pulse one cycle, wrap=0; then d=3 -> q=3 with no err.
REQ-036 Hold/enable: q=5, en=0 with mode=01 for 3 edges -> q stays 5, t_out=0, tc=0; qb=~q checked every cycle.
REQ-037 Full modulus: WIDTH=4, MOD=16, up from 15 -> q=0, wrap=1; random mode/en/d for 10k cycles checked against a reference model.
